// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, FSM states and
// byte-lane geometry helpers derived from the datapath width.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  function automatic int calc_nb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int calc_lb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Byte-offset bits that must be zero for a naturally aligned access of size sz
  function automatic logic [7:0] low_mask(input logic [1:0] sz);
    return 8'((9'd1 << sz) - 9'd1);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables and replicated store data for a
// write, and shift/truncate/extend of read data for a load.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = calc_nb(DATA_W),
  localparam int LB = calc_lb(DATA_W)
) (
  input  logic [LB-1:0]     addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] ld_raw,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data
);

  localparam int DW_TOP = (DATA_W >= 64) ? 63 : 31;

  logic [1:0]        eff_size;
  logic [LB-1:0]     size_mask;
  logic [LB-1:0]     lane;
  logic [DATA_W-1:0] shifted;
  logic              sign_raw;
  logic              sign;
  int                nbytes;

  // Sizes wider than the datapath are clamped; misaligned offset bits are
  // dropped so the access always sits on its natural boundary.
  always_comb begin
    eff_size = (int'(size) > LB) ? 2'(LB) : size;
    nbytes   = 1 << eff_size;
    for (int b = 0; b < LB; b++) begin
      size_mask[b] = (b < int'(eff_size));
    end
    lane = addr_lo & ~size_mask;

    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(lane)) && (i < int'(lane) + nbytes);
      case (eff_size)
        SZ_B:    wdata[8*i +: 8] = st_data[7:0];
        SZ_H:    wdata[8*i +: 8] = st_data[8*(i % 2) +: 8];
        SZ_W:    wdata[8*i +: 8] = st_data[8*(i % 4) +: 8];
        default: wdata[8*i +: 8] = st_data[8*(i % 8) +: 8];
      endcase
    end

    shifted = ld_raw >> {lane, 3'b000};
    case (eff_size)
      SZ_B:    sign_raw = shifted[7];
      SZ_H:    sign_raw = shifted[15];
      SZ_W:    sign_raw = shifted[31];
      default: sign_raw = shifted[DW_TOP];
    endcase
    sign = sign_raw & ~is_unsigned;

    for (int j = 0; j < DATA_W; j++) begin
      ld_data[j] = (j < 8 * nbytes) ? shifted[j] : sign;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// EX->WB memory stage: issues sub-word loads/stores over a req/ack data-memory
// port, stalls EX while an access is outstanding, and registers the WB fields.
// Optional build macro: MEM_MISALIGN_EXC_EN (trap misaligned accesses).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RA_W   = 5,
  localparam int NB = calc_nb(DATA_W),
  localparam int LB = calc_lb(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_memto_reg,
  input  logic              ex_branch,
  input  logic              ex_alu_zero,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rdata2,
  input  logic [RA_W-1:0]   ex_regdst,

  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [NB-1:0]     dm_be,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,

  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_memto_reg,
  output logic              wb_pcsrc,
  output logic              wb_exc,
  output logic [ADDR_W-1:0] wb_pc,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_memdata,
  output logic [RA_W-1:0]   wb_regdst
);

  state_t state, state_next;

  logic accept, issue, complete, trap, mis;

  logic              op_reg_write;
  logic              op_memto_reg;
  logic              op_pcsrc;
  logic [1:0]        op_size;
  logic              op_unsigned;
  logic [ADDR_W-1:0] op_pc;
  logic [DATA_W-1:0] op_alu_result;
  logic [RA_W-1:0]   op_regdst;

  logic [LB-1:0]     al_addr_lo;
  logic [1:0]        al_size;
  logic              al_unsigned;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_ld_data;

`ifdef MEM_MISALIGN_EXC_EN
  assign mis = |(ex_alu_result[LB-1:0] & LB'(low_mask(ex_size)));
`else
  assign mis = 1'b0;
`endif

  assign ex_ready = (state == ST_IDLE);

  // One aligner serves both phases: EX inputs while idle (store setup),
  // the latched op while waiting for the ack (load extraction).
  assign al_addr_lo  = (state == ST_IDLE) ? ex_alu_result[LB-1:0] : op_alu_result[LB-1:0];
  assign al_size     = (state == ST_IDLE) ? ex_size : op_size;
  assign al_unsigned = (state == ST_IDLE) ? ex_unsigned : op_unsigned;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .st_data     (ex_rdata2),
    .ld_raw      (dm_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .ld_data     (al_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    trap       = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid) begin
          accept = 1'b1;
          if (ex_mem_read || ex_mem_write) begin
            if (mis) begin
              trap = 1'b1;
            end else begin
              issue      = 1'b1;
              state_next = ST_ACCESS;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (dm_ack) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // WB fields are cleared every cycle they are not written so that each
  // result, including wb_pcsrc, is visible for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_memto_reg  <= 1'b0;
      wb_pcsrc      <= 1'b0;
      wb_pc         <= '0;
      wb_alu_result <= '0;
      wb_memdata    <= '0;
      wb_regdst     <= '0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      dm_be         <= '0;
      op_reg_write  <= 1'b0;
      op_memto_reg  <= 1'b0;
      op_pcsrc      <= 1'b0;
      op_size       <= SZ_B;
      op_unsigned   <= 1'b0;
      op_pc         <= '0;
      op_alu_result <= '0;
      op_regdst     <= '0;
    end else begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_memto_reg  <= 1'b0;
      wb_pcsrc      <= 1'b0;
      wb_pc         <= '0;
      wb_alu_result <= '0;
      wb_memdata    <= '0;
      wb_regdst     <= '0;

      if (accept && !issue) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= ex_reg_write & ~trap;
        wb_memto_reg  <= ex_memto_reg & ~trap;
        wb_pcsrc      <= ex_branch & ex_alu_zero;
        wb_pc         <= ex_pc;
        wb_alu_result <= ex_alu_result;
        wb_regdst     <= ex_regdst;
      end

      if (issue) begin
        op_reg_write  <= ex_reg_write;
        op_memto_reg  <= ex_memto_reg;
        op_pcsrc      <= ex_branch & ex_alu_zero;
        op_size       <= ex_size;
        op_unsigned   <= ex_unsigned;
        op_pc         <= ex_pc;
        op_alu_result <= ex_alu_result;
        op_regdst     <= ex_regdst;
        dm_req        <= 1'b1;
        dm_we         <= ex_mem_write;
        dm_addr       <= {ex_alu_result[ADDR_W-1:LB], LB'(0)};
        dm_wdata      <= al_wdata;
        dm_be         <= al_be;
      end

      if (complete) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= op_reg_write;
        wb_memto_reg  <= op_memto_reg;
        wb_pcsrc      <= op_pcsrc;
        wb_pc         <= op_pc;
        wb_alu_result <= op_alu_result;
        wb_regdst     <= op_regdst;
        wb_memdata    <= dm_we ? '0 : al_ld_data;
        dm_req        <= 1'b0;
        dm_we         <= 1'b0;
        dm_addr       <= '0;
        dm_wdata      <= '0;
        dm_be         <= '0;
      end
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_exc <= 1'b0;
    end else begin
      wb_exc <= trap;
    end
  end
`else
  assign wb_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit; honours MEM_MISALIGN_EXC_EN
// when the design is built with it.
module tb_mem_access_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int RA_W   = 5;
  localparam int NB     = DATA_W / 8;

`ifdef MEM_MISALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_ready;
  logic              ex_mem_read, ex_mem_write, ex_reg_write, ex_memto_reg;
  logic              ex_branch, ex_alu_zero, ex_unsigned;
  logic [1:0]        ex_size;
  logic [ADDR_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_alu_result, ex_rdata2;
  logic [RA_W-1:0]   ex_regdst;
  logic              dm_req, dm_we, dm_ack;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic [NB-1:0]     dm_be;
  logic              wb_valid, wb_reg_write, wb_memto_reg, wb_pcsrc, wb_exc;
  logic [ADDR_W-1:0] wb_pc;
  logic [DATA_W-1:0] wb_alu_result, wb_memdata;
  logic [RA_W-1:0]   wb_regdst;

  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic        pcsrc;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] memdata;
    logic [4:0]  regdst;
  } wb_t;

  wb_t sb[$];
  int  tests_run    = 0;
  int  tests_failed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RA_W(RA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_memto_reg  (ex_memto_reg),
    .ex_branch     (ex_branch),
    .ex_alu_zero   (ex_alu_zero),
    .ex_size       (ex_size),
    .ex_unsigned   (ex_unsigned),
    .ex_pc         (ex_pc),
    .ex_alu_result (ex_alu_result),
    .ex_rdata2     (ex_rdata2),
    .ex_regdst     (ex_regdst),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_be         (dm_be),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_memto_reg  (wb_memto_reg),
    .wb_pcsrc      (wb_pcsrc),
    .wb_exc        (wb_exc),
    .wb_pc         (wb_pc),
    .wb_alu_result (wb_alu_result),
    .wb_memdata    (wb_memdata),
    .wb_regdst     (wb_regdst)
  );

  // Reference load: pick the size-aligned lane, then truncate and extend
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    int          nbytes;
    int          lane;
    logic [31:0] v;
    nbytes = 1 << size;
    lane   = (int'(addr % 32'd4) / nbytes) * nbytes;
    v      = rdata >> (8 * lane);
    case (size)
      2'd0:    model_load = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'd1:    model_load = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: model_load = v;
    endcase
  endfunction

  task automatic checkSignal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    ex_valid      = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_reg_write  = 1'b0;
    ex_memto_reg  = 1'b0;
    ex_branch     = 1'b0;
    ex_alu_zero   = 1'b0;
    ex_size       = 2'd0;
    ex_unsigned   = 1'b0;
    ex_pc         = '0;
    ex_alu_result = '0;
    ex_rdata2     = '0;
    ex_regdst     = '0;
  endtask

  // Presents one op for a single cycle (caller guarantees ex_ready) and, if
  // a WB result is expected, pushes the reference record to the scoreboard.
  task automatic applyStimulus(input logic rd, input logic wr, input logic rw, input logic m2r,
                               input logic br, input logic z, input logic [1:0] size,
                               input logic uns, input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] st, input logic [4:0] rdst,
                               input logic [31:0] planned_rdata, input bit expect_wb);
    wb_t  e;
    logic trap;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_reg_write  = rw;
    ex_memto_reg  = m2r;
    ex_branch     = br;
    ex_alu_zero   = z;
    ex_size       = size;
    ex_unsigned   = uns;
    ex_pc         = pc;
    ex_alu_result = alu;
    ex_rdata2     = st;
    ex_regdst     = rdst;
    ex_valid      = 1'b1;
    trap = EXC_EN && (rd || wr) && ((alu & ((32'd1 << size) - 32'd1)) != 32'd0);
    e.reg_write = trap ? 1'b0 : rw;
    e.memto_reg = trap ? 1'b0 : m2r;
    e.pcsrc     = br & z;
    e.exc       = trap;
    e.pc        = pc;
    e.alu       = alu;
    e.regdst    = rdst;
    e.memdata   = (rd && !wr && !trap) ? model_load(planned_rdata, alu, size, uns) : 32'h0;
    if (expect_wb) sb.push_back(e);
    @(negedge clk);
    clearInputs();
  endtask

  task automatic checkOutput(input string tag);
    wb_t e;
    checkSignal({tag, "_valid"}, wb_valid, 1'b1);
    checkSignal({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkSignal({tag, "_reg_write"}, wb_reg_write, e.reg_write);
    checkSignal({tag, "_memto_reg"}, wb_memto_reg, e.memto_reg);
    checkSignal({tag, "_pcsrc"}, wb_pcsrc, e.pcsrc);
    checkSignal({tag, "_exc"}, wb_exc, e.exc);
    checkSignal({tag, "_pc"}, wb_pc, e.pc);
    checkSignal({tag, "_alu"}, wb_alu_result, e.alu);
    checkSignal({tag, "_memdata"}, wb_memdata, e.memdata);
    checkSignal({tag, "_regdst"}, 32'(wb_regdst), 32'(e.regdst));
  endtask

  initial begin
    clearInputs();
    rst      = 1'b1;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    repeat (2) @(negedge clk);

    checkSignal("rst_ex_ready", ex_ready, 1'b1);
    checkSignal("rst_wb_valid", wb_valid, 1'b0);
    checkSignal("rst_dm_req", dm_req, 1'b0);
    checkSignal("rst_dm_we", dm_we, 1'b0);
    checkSignal("rst_dm_be", 32'(dm_be), 32'h0);
    checkSignal("rst_dm_addr", dm_addr, 32'h0);
    checkSignal("rst_dm_wdata", dm_wdata, 32'h0);
    checkSignal("rst_wb_alu", wb_alu_result, 32'h0);
    checkSignal("rst_wb_exc", wb_exc, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkSignal("post_rst_ready", ex_ready, 1'b1);

    // Non-memory op
    applyStimulus(0, 0, 1, 0, 0, 0, 2'd2, 0, 32'h100, 32'h1234, 32'hDEAD, 5'd7, 32'h0, 1);
    checkOutput("nonmem");
    checkSignal("nonmem_dm_req", dm_req, 1'b0);
    @(negedge clk);
    checkSignal("nonmem_pulse", wb_valid, 1'b0);

    // Back-to-back: taken branch then a plain op; pcsrc must last one cycle
    applyStimulus(0, 0, 0, 0, 1, 1, 2'd2, 0, 32'h104, 32'h0, 32'h0, 5'd0, 32'h0, 1);
    checkOutput("branch_taken");
    applyStimulus(0, 0, 1, 0, 0, 1, 2'd2, 0, 32'h108, 32'h55, 32'h0, 5'd2, 32'h0, 1);
    checkOutput("after_branch");
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd2, 0, 32'h10C, 32'h9, 32'h0, 5'd0, 32'h0, 1);
    checkOutput("branch_not_taken");

    // Store byte 0xA5 to 0x1003, ack two cycles after issue
    applyStimulus(0, 1, 0, 0, 0, 0, 2'd0, 0, 32'h200, 32'h1003, 32'h000000A5, 5'd0, 32'h0, 1);
    checkSignal("sb_req", dm_req, 1'b1);
    checkSignal("sb_we", dm_we, 1'b1);
    checkSignal("sb_be", 32'(dm_be), 32'h8);
    checkSignal("sb_wdata", dm_wdata, 32'hA5A5A5A5);
    checkSignal("sb_addr", dm_addr, 32'h1000);
    checkSignal("sb_ready_low", ex_ready, 1'b0);
    checkSignal("sb_no_wb", wb_valid, 1'b0);
    @(negedge clk);
    checkSignal("sb_req_hold", dm_req, 1'b1);
    checkSignal("sb_addr_hold", dm_addr, 32'h1000);
    checkSignal("sb_be_hold", 32'(dm_be), 32'h8);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    checkOutput("store_byte");
    checkSignal("sb_req_drop", dm_req, 1'b0);
    checkSignal("sb_ready_back", ex_ready, 1'b1);

    // Load half signed from 0x2002, ack three cycles after acceptance
    dm_rdata = 32'h8001_0000;
    applyStimulus(1, 0, 1, 1, 0, 0, 2'd1, 0, 32'h300, 32'h2002, 32'h0, 5'd9, 32'h8001_0000, 1);
    checkSignal("lh_be", 32'(dm_be), 32'hC);
    checkSignal("lh_addr", dm_addr, 32'h2000);
    checkSignal("lh_we", dm_we, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkSignal("lh_wait_ready", ex_ready, 1'b0);
      checkSignal("lh_wait_req", dm_req, 1'b1);
    end
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    checkOutput("load_half_signed");

    // Same load unsigned, minimum latency
    applyStimulus(1, 0, 1, 1, 0, 0, 2'd1, 1, 32'h304, 32'h2002, 32'h0, 5'd10, 32'h8001_0000, 1);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    checkOutput("load_half_unsigned");

    // Signed byte from top lane
    dm_rdata = 32'h80FF_7F00;
    applyStimulus(1, 0, 1, 1, 0, 0, 2'd0, 0, 32'h308, 32'h4003, 32'h0, 5'd11, 32'h80FF_7F00, 1);
    checkSignal("lb_be", 32'(dm_be), 32'h8);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    checkOutput("load_byte_signed");

    // Read and write both set behaves as a half store to 0x1006
    applyStimulus(1, 1, 0, 0, 0, 0, 2'd1, 0, 32'h30C, 32'h1006, 32'h1234BEEF, 5'd0, 32'h0, 1);
    checkSignal("sh_we", dm_we, 1'b1);
    checkSignal("sh_be", 32'(dm_be), 32'hC);
    checkSignal("sh_wdata", dm_wdata, 32'hBEEFBEEF);
    checkSignal("sh_addr", dm_addr, 32'h1004);
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    checkOutput("store_half_rw");

    // Stray ack while idle
    dm_ack = 1'b1;
    @(negedge clk);
    dm_ack = 1'b0;
    checkSignal("idle_ack_wb", wb_valid, 1'b0);
    checkSignal("idle_ack_req", dm_req, 1'b0);
    checkSignal("idle_ack_ready", ex_ready, 1'b1);

    // Reset during ACCESS coincident with ack: result discarded
    dm_rdata = 32'hCAFE_F00D;
    applyStimulus(1, 0, 1, 1, 0, 0, 2'd2, 0, 32'h400, 32'h5000, 32'h0, 5'd4, 32'h0, 0);
    checkSignal("rst_acc_req", dm_req, 1'b1);
    rst    = 1'b1;
    dm_ack = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    dm_ack = 1'b0;
    checkSignal("rst_acc_wb", wb_valid, 1'b0);
    checkSignal("rst_acc_req_drop", dm_req, 1'b0);
    checkSignal("rst_acc_ready", ex_ready, 1'b1);
    checkSignal("rst_acc_be", 32'(dm_be), 32'h0);
    checkSignal("rst_acc_addr", dm_addr, 32'h0);
    checkSignal("rst_acc_regw", wb_reg_write, 1'b0);
    @(negedge clk);
    checkSignal("rst_acc_wb_late", wb_valid, 1'b0);

    // Misaligned load word at 0x3001
    dm_rdata = 32'h1122_3344;
    applyStimulus(1, 0, 1, 1, 0, 0, 2'd2, 0, 32'h500, 32'h3001, 32'h0, 5'd3, 32'h1122_3344, 1);
    if (EXC_EN) begin
      checkOutput("misaligned_trap");
      checkSignal("mis_no_req", dm_req, 1'b0);
    end else begin
      checkSignal("mis_req", dm_req, 1'b1);
      checkSignal("mis_addr", dm_addr, 32'h3000);
      checkSignal("mis_be", 32'(dm_be), 32'hF);
      dm_ack = 1'b1;
      @(negedge clk);
      dm_ack = 1'b0;
      checkOutput("misaligned_load");
    end

    @(negedge clk);
    checkSignal("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
